alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Registered, parametrised successor to the combinational ALU control decoder.
- Decodes funct/aluOp into aluSrc/aluSel behind a valid/ready handshake.
- Optionally sequences variable-amount shifts as single-bit steps so a 1-bit shifter can be used in the datapath.
- Sits between the main control unit/ID stage and the ALU; flags unmapped R-type functs.

Parameters:
FUNCT_W, 6, funct field width (>=6; bits above [5:0] must be zero for a mapped code)
ALUOP_W, 3, aluOp width (>=3; bits above [2:0] must be zero for a mapped code)
SEL_W, 4, aluSel width (>=4; upper bits driven 0)
SHAMT_W, 5, shift-amount width
ITER_SHIFT, 1, 1 = iterate shifts one bit per cycle; 0 = single-cycle decode for all ops

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  block can accept request this cycle
funct  in  FUNCT_W  R-type function code
aluOp  in  ALUOP_W  ALU operation class from main control
shamt  in  SHAMT_W  shift amount, used only when ITER_SHIFT=1
aluSrc  out  1  1 = second ALU operand is immediate
aluSel  out  SEL_W  ALU function select
out_valid  out  1  aluSrc/aluSel/illegal valid; one-cycle pulse per request
step_en  out  1  datapath performs one 1-bit shift this cycle
busy  out  1  iterative shift in progress
illegal  out  1  aluOp class 0 with unmapped funct; valid with out_valid

Behaviour:
- Decode table (aluSrc, aluSel):
  - aluOp=0, funct 0..10 -> (0,0),(0,1),(0,2),(0,3),(1,4),(1,5),(0,4),(0,5),(1,6),(0,6),(0,9).
  - aluOp=0, any other funct -> (1,F) with illegal=1.
  - aluOp=3 -> (1,0); aluOp=2 -> (1,1); aluOp=4 -> (1,0); any other aluOp -> (1,8).
- Shift class: aluSel in {4,5,6} with aluOp=0.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE) & ~rst. Accept occurs when in_valid & in_ready; funct/aluOp/shamt are sampled only on accept.
- IDLE, accept, non-shift op, ITER_SHIFT=0, or shamt=0:
  - Next cycle: out_valid=1 with decoded outputs, step_en=0.
  - Stay IDLE; back-to-back accepts allowed, giving one result per cycle with 1-cycle latency.
- IDLE, accept, shift class, ITER_SHIFT=1, shamt=N>=1:
  - Latch decode; load counter with N; go to SHIFT. busy=1 from the next cycle.
  - In SHIFT: step_en=1 every cycle and aluSel/aluSrc held; counter decrements each cycle.
  - On the cycle the counter equals 1: step_en=1, out_valid=1, busy=1, then return to IDLE.
  - Exactly N step_en cycles; out_valid coincides with the Nth step. Latency from accept to out_valid is N cycles.
- Maximum shamt (2^SHAMT_W-1) must not wrap; the counter is SHAMT_W bits and never decrements below 1 in SHIFT.
- in_valid while busy: ignored; the requester holds it until in_ready.
- out_valid=0 cycles: aluSrc/aluSel/illegal hold their last values; illegal is meaningful only with out_valid.
- Reset values: aluSrc=0, aluSel=0, out_valid=0, step_en=0, busy=0, illegal=0, state=IDLE, counter=0, in_ready=0 while rst=1.
- rst mid-SHIFT: aborts next edge with no out_valid and no further step_en; in_ready=1 the cycle after rst deasserts.
- rst and in_valid in the same cycle: request is not accepted.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> all outputs 0, in_ready=0; release -> in_ready=1, no out_valid.
- Back-to-back decode: accept (aluOp=0,funct=2), (aluOp=3), (aluOp=7) on consecutive cycles -> out_valid three consecutive cycles with (0,2), (1,0), (1,8); illegal=0.
- Illegal funct: aluOp=0, funct=6'b111111 -> one cycle later out_valid=1, aluSrc=1, aluSel=F, illegal=1.
- Iterative shift: ITER_SHIFT=1, aluOp=0, funct=4, shamt=3 -> step_en=1 for exactly 3 cycles with aluSel=4, aluSrc=1; out_valid on the 3rd; in_ready=0 for those 3 cycles; in_valid held during busy is accepted the cycle after.
- Edge shamts: shamt=0 on funct=5 -> single out_valid, no step_en. shamt=31 on funct=9 -> 31 step_en cycles, one out_valid. With ITER_SHIFT=0, shamt=31 -> 1-cycle result.
- Reset mid-shift: shamt=10, assert rst after 4 steps -> step_en and busy low next cycle, no out_valid; a new request after release decodes correctly.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ----------------------------------------------------------------------------
// alu_ctrl_seq : registered ALU control decoder with valid/ready handshake and
//                optional one-bit-per-cycle shift sequencing.
// Revision     : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_seq #(
    parameter int FUNCT_W    = 6,
    parameter int ALUOP_W    = 3,
    parameter int SEL_W      = 4,
    parameter int SHAMT_W    = 5,
    parameter int ITER_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [ALUOP_W-1:0] aluOp,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               aluSrc,
    output logic [SEL_W-1:0]   aluSel,
    output logic               out_valid,
    output logic               step_en,
    output logic               busy,
    output logic               illegal
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;

    logic       dec_src;
    logic [3:0] dec_sel;
    logic       dec_ill;
    logic       funct_ok;
    logic       op_ok;
    logic       is_shift;
    logic       go_iter;
    logic       accept;

    assign in_ready = (state == IDLE) & ~rst;
    assign accept   = in_valid & in_ready;

    // Upper field bits beyond the architected width must be zero to map.
    assign funct_ok = ((funct >> 6) == '0);
    assign op_ok    = ((aluOp >> 3) == '0);

    always_comb begin
        dec_src = 1'b1;
        dec_sel = 4'h8;
        dec_ill = 1'b0;
        if (op_ok) begin
            case (aluOp[2:0])
                3'd0: begin
                    if (funct_ok && (funct[5:0] <= 6'd10)) begin
                        case (funct[5:0])
                            6'd0:    begin dec_src = 1'b0; dec_sel = 4'h0; end
                            6'd1:    begin dec_src = 1'b0; dec_sel = 4'h1; end
                            6'd2:    begin dec_src = 1'b0; dec_sel = 4'h2; end
                            6'd3:    begin dec_src = 1'b0; dec_sel = 4'h3; end
                            6'd4:    begin dec_src = 1'b1; dec_sel = 4'h4; end
                            6'd5:    begin dec_src = 1'b1; dec_sel = 4'h5; end
                            6'd6:    begin dec_src = 1'b0; dec_sel = 4'h4; end
                            6'd7:    begin dec_src = 1'b0; dec_sel = 4'h5; end
                            6'd8:    begin dec_src = 1'b1; dec_sel = 4'h6; end
                            6'd9:    begin dec_src = 1'b0; dec_sel = 4'h6; end
                            default: begin dec_src = 1'b0; dec_sel = 4'h9; end
                        endcase
                    end else begin
                        dec_src = 1'b1;
                        dec_sel = 4'hF;
                        dec_ill = 1'b1;
                    end
                end
                3'd2:    begin dec_src = 1'b1; dec_sel = 4'h1; end
                3'd3:    begin dec_src = 1'b1; dec_sel = 4'h0; end
                3'd4:    begin dec_src = 1'b1; dec_sel = 4'h0; end
                default: begin dec_src = 1'b1; dec_sel = 4'h8; end
            endcase
        end
    end

    assign is_shift = op_ok && (aluOp[2:0] == 3'd0) && !dec_ill &&
                      ((dec_sel == 4'h4) || (dec_sel == 4'h5) || (dec_sel == 4'h6));
    assign go_iter  = (ITER_SHIFT != 0) && is_shift && (shamt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            aluSrc    <= 1'b0;
            aluSel    <= '0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            step_en   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    step_en   <= 1'b0;
                    busy      <= 1'b0;
                    if (accept) begin
                        aluSrc  <= dec_src;
                        aluSel  <= SEL_W'(dec_sel);
                        illegal <= dec_ill;
                        if (go_iter) begin
                            state     <= SHIFT;
                            cnt       <= shamt;
                            step_en   <= 1'b1;
                            busy      <= 1'b1;
                            out_valid <= (shamt == SHAMT_W'(1));
                        end else begin
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // Counter shows the steps still to run, including this one.
                    if (cnt == SHAMT_W'(1)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        step_en   <= 1'b0;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end else begin
                        cnt       <= cnt - SHAMT_W'(1);
                        step_en   <= 1'b1;
                        busy      <= 1'b1;
                        out_valid <= (cnt == SHAMT_W'(2));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_ctrl_seq : directed self-checking bench for alu_ctrl_seq (iterative
//                   and single-cycle configurations side by side).
// Revision        : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] funct;
    logic [2:0] aluOp;
    logic [4:0] shamt;

    logic       in_ready, aluSrc, out_valid, step_en, busy, illegal;
    logic [3:0] aluSel;
    logic       in_ready0, aluSrc0, out_valid0, step_en0, busy0, illegal0;
    logic [3:0] aluSel0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(.FUNCT_W(6), .ALUOP_W(3), .SEL_W(4), .SHAMT_W(5), .ITER_SHIFT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .aluOp(aluOp), .shamt(shamt),
        .aluSrc(aluSrc), .aluSel(aluSel), .out_valid(out_valid),
        .step_en(step_en), .busy(busy), .illegal(illegal)
    );

    alu_ctrl_seq #(.FUNCT_W(6), .ALUOP_W(3), .SEL_W(4), .SHAMT_W(5), .ITER_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .funct(funct), .aluOp(aluOp), .shamt(shamt),
        .aluSrc(aluSrc0), .aluSel(aluSel0), .out_valid(out_valid0),
        .step_en(step_en0), .busy(busy0), .illegal(illegal0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int steps;
        int ovs;
        int ov_at;

        rst = 1'b1; in_valid = 1'b1; funct = 6'd2; aluOp = 3'd0; shamt = 5'd0;

        // Reset held two cycles with a request pending.
        tick();
        tick();
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_step_en",   8'(step_en),   8'd0);
        chk("rst_busy",      8'(busy),      8'd0);
        chk("rst_aluSrc",    8'(aluSrc),    8'd0);
        chk("rst_aluSel",    8'(aluSel),    8'd0);
        chk("rst_illegal",   8'(illegal),   8'd0);
        chk("rst_in_ready",  8'(in_ready),  8'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 8'(in_ready), 8'd1);
        tick();
        chk("rel_no_valid", 8'(out_valid), 8'd0);

        // Back-to-back single-cycle decodes.
        in_valid = 1'b1; aluOp = 3'd0; funct = 6'd2;
        tick();
        chk("b2b0_valid", 8'(out_valid), 8'd1);
        chk("b2b0_src",   8'(aluSrc),    8'd0);
        chk("b2b0_sel",   8'(aluSel),    8'd2);
        chk("b2b0_ill",   8'(illegal),   8'd0);
        aluOp = 3'd3;
        tick();
        chk("b2b1_valid", 8'(out_valid), 8'd1);
        chk("b2b1_src",   8'(aluSrc),    8'd1);
        chk("b2b1_sel",   8'(aluSel),    8'd0);
        aluOp = 3'd7;
        tick();
        chk("b2b2_valid", 8'(out_valid), 8'd1);
        chk("b2b2_src",   8'(aluSrc),    8'd1);
        chk("b2b2_sel",   8'(aluSel),    8'd8);
        chk("b2b2_ill",   8'(illegal),   8'd0);
        in_valid = 1'b0;
        tick();
        chk("idle_valid", 8'(out_valid), 8'd0);
        chk("idle_hold",  8'(aluSel),    8'd8);

        // Unmapped R-type funct.
        in_valid = 1'b1; aluOp = 3'd0; funct = 6'h3F;
        tick();
        chk("ill_valid", 8'(out_valid), 8'd1);
        chk("ill_src",   8'(aluSrc),    8'd1);
        chk("ill_sel",   8'(aluSel),    8'hF);
        chk("ill_flag",  8'(illegal),   8'd1);
        chk("ill_flag0", 8'(illegal0),  8'd1);
        in_valid = 1'b0;
        tick();

        // Iterative shift of 3 with the next request held during busy.
        in_valid = 1'b1; aluOp = 3'd0; funct = 6'd4; shamt = 5'd3;
        tick();
        funct = 6'd2; shamt = 5'd0;
        chk("sh1_step",  8'(step_en),  8'd1);
        chk("sh1_busy",  8'(busy),     8'd1);
        chk("sh1_valid", 8'(out_valid),8'd0);
        chk("sh1_sel",   8'(aluSel),   8'd4);
        chk("sh1_src",   8'(aluSrc),   8'd1);
        chk("sh1_ready", 8'(in_ready), 8'd0);
        tick();
        chk("sh2_step",  8'(step_en),  8'd1);
        chk("sh2_valid", 8'(out_valid),8'd0);
        chk("sh2_ready", 8'(in_ready), 8'd0);
        tick();
        chk("sh3_step",  8'(step_en),  8'd1);
        chk("sh3_valid", 8'(out_valid),8'd1);
        chk("sh3_sel",   8'(aluSel),   8'd4);
        chk("sh3_ready", 8'(in_ready), 8'd0);
        tick();
        chk("sh4_step",  8'(step_en),  8'd0);
        chk("sh4_busy",  8'(busy),     8'd0);
        chk("sh4_valid", 8'(out_valid),8'd0);
        chk("sh4_ready", 8'(in_ready), 8'd1);
        tick();
        in_valid = 1'b0;
        chk("held_valid", 8'(out_valid), 8'd1);
        chk("held_sel",   8'(aluSel),    8'd2);
        chk("held_src",   8'(aluSrc),    8'd0);
        tick();

        // shamt=0 on a shift op completes in one cycle.
        in_valid = 1'b1; funct = 6'd5; shamt = 5'd0;
        tick();
        in_valid = 1'b0;
        chk("s0_valid", 8'(out_valid), 8'd1);
        chk("s0_step",  8'(step_en),   8'd0);
        chk("s0_busy",  8'(busy),      8'd0);
        chk("s0_sel",   8'(aluSel),    8'd5);
        tick();
        chk("s0_once",  8'(out_valid), 8'd0);

        // Maximum shamt: 31 steps iterative, one cycle when not iterating.
        in_valid = 1'b1; funct = 6'd9; shamt = 5'd31;
        tick();
        in_valid = 1'b0;
        chk("max0_valid", 8'(out_valid0), 8'd1);
        chk("max0_step",  8'(step_en0),   8'd0);
        chk("max0_sel",   8'(aluSel0),    8'd6);
        chk("max0_src",   8'(aluSrc0),    8'd0);
        steps = 0; ovs = 0; ov_at = 0;
        for (int i = 0; i < 40; i++) begin
            if (step_en) steps++;
            if (out_valid) begin
                ovs++;
                ov_at = steps;
            end
            tick();
        end
        chk("max_steps", 8'(steps), 8'd31);
        chk("max_ovs",   8'(ovs),   8'd1);
        chk("max_ov_at", 8'(ov_at), 8'd31);
        chk("max_idle",  8'(in_ready), 8'd1);

        // Reset during a 10-step shift after 4 steps.
        in_valid = 1'b1; funct = 6'd4; shamt = 5'd10;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_step4", 8'(step_en), 8'd1);
        rst = 1'b1;
        tick();
        chk("mid_step", 8'(step_en),  8'd0);
        chk("mid_busy", 8'(busy),     8'd0);
        chk("mid_valid",8'(out_valid),8'd0);
        rst = 1'b0;
        #1;
        chk("mid_ready", 8'(in_ready), 8'd1);
        in_valid = 1'b1; aluOp = 3'd2; funct = 6'd0;
        tick();
        in_valid = 1'b0;
        chk("post_valid", 8'(out_valid), 8'd1);
        chk("post_src",   8'(aluSrc),    8'd1);
        chk("post_sel",   8'(aluSel),    8'd1);
        chk("post_ill",   8'(illegal),   8'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
